// File: rtl/core_global_avg_pooling_1.sv
// Global average pooling: sums WIDTH*WIDTH words per channel from a show-ahead
// FIFO, scales by a fixed-point reciprocal, rounds, saturates and pushes one result.
module core_global_avg_pooling_1 #(
  parameter int DWIDTH   = 32,
  parameter int WIDTH    = 7,
  parameter int CHANNELS = 512,
  parameter int RECIP    = 1337,
  parameter int SHIFT    = 16,
  parameter int ACC_W    = DWIDTH + 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DWIDTH-1:0] ff_rdata,
  output logic              ff_rdreq,
  input  logic              ff_empty,
  output logic [DWIDTH-1:0] ff_wdata,
  output logic              ff_wrreq,
  input  logic              ff_full,
  output logic              frame_done,
  output logic [1:0]        state_dbg
);

  localparam int NWORDS = WIDTH * WIDTH;
  localparam int WC_W   = $clog2(NWORDS + 1);
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW     = ACC_W + SHIFT + 1;

  localparam logic signed [PW-1:0] RECIP_X = PW'(RECIP);
  localparam logic signed [PW-1:0] HALF    = PW'(2 ** (SHIFT - 1));
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ACC = 2'd0,
    MUL = 2'd1,
    RND = 2'd2,
    OUT = 2'd3
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic signed [ACC_W-1:0]  acc;
  logic signed [PW-1:0]     prod;
  logic [DWIDTH-1:0]        result;
  logic [WC_W-1:0]          word_cnt;
  logic [CH_W-1:0]          ch_cnt;

  logic                     last_word;
  logic signed [ACC_W-1:0]  word_ext;
  logic signed [PW-1:0]     acc_x;
  logic signed [PW-1:0]     prod_next;
  logic signed [PW-1:0]     rounded;
  logic [DWIDTH-1:0]        sat_next;

  // Handshake: a word is consumed on every rising edge where ff_rdreq=1, and a
  // result is pushed on every rising edge where ff_wrreq=1; both are forced low in reset.
  assign ff_rdreq  = reset && (state == ACC) && !ff_empty;
  assign ff_wrreq  = reset && (state == OUT) && !ff_full;
  assign ff_wdata  = result;
  assign state_dbg = state;

  assign last_word = (word_cnt == WC_W'(NWORDS - 1));
  assign word_ext  = {{(ACC_W-DWIDTH){ff_rdata[DWIDTH-1]}}, ff_rdata};
  assign acc_x     = {{(PW-ACC_W){acc[ACC_W-1]}}, acc};
  assign prod_next = acc_x * RECIP_X;
  assign rounded   = (prod + HALF) >>> SHIFT;

  always_comb begin
    sat_next = rounded[DWIDTH-1:0];
    if (rounded > SAT_MAX) begin
      sat_next = SAT_MAX[DWIDTH-1:0];
    end else if (rounded < SAT_MIN) begin
      sat_next = SAT_MIN[DWIDTH-1:0];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ACC: if (ff_rdreq && last_word) state_next = MUL;
      MUL: state_next = RND;
      RND: state_next = OUT;
      OUT: if (!ff_full) state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ACC;
      acc        <= '0;
      prod       <= '0;
      result     <= '0;
      word_cnt   <= '0;
      ch_cnt     <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= 1'b0;
      case (state)
        ACC: begin
          if (ff_rdreq) begin
            acc <= acc + word_ext;
            if (last_word) begin
              word_cnt <= '0;
            end else begin
              word_cnt <= word_cnt + WC_W'(1);
            end
          end
        end
        MUL: prod <= prod_next;
        RND: result <= sat_next;
        OUT: begin
          // Everything holds while the downstream FIFO is full.
          if (!ff_full) begin
            acc <= '0;
            if (ch_cnt == CH_W'(CHANNELS - 1)) begin
              ch_cnt     <= '0;
              frame_done <= 1'b1;
            end else begin
              ch_cnt <= ch_cnt + CH_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
